// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter
//   Time-shares one basic_gates unit (a,b -> g1..g5) among NUM_REQ requesters.
//   A winner is picked in IDLE, its a/b are driven onto the shared unit for
//   SETTLE_CYC cycles, g1..g5 are captured in SAMPLE, and a one-cycle
//   rsp_valid strobe goes back to the winner in RESP.
//
//   Optional build macro: GATE_ARB_FIXED_PRI_EN
//     defined   -> fixed priority, lowest asserted index wins (no rotating pointer)
//     undefined -> round-robin starting at rr_ptr
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot, IDLE only)
//   req_a/req_b             per-requester operand bits
//   req_sel                 3 bits per requester, 0..4 selects g1..g5
//   rsp_valid               one-cycle strobe to the served requester
//   rsp_vec/rsp_y/rsp_err   captured gate vector, selected bit, bad-select flag
//   busy                    high whenever not IDLE
//   gate_a/gate_b/gate_g    connection to the shared gate unit

module gate_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_a,
    input  logic [NUM_REQ-1:0]     req_b,
    input  logic [3*NUM_REQ-1:0]   req_sel,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [4:0]             rsp_vec,
    output logic                   rsp_y,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   gate_a,
    output logic                   gate_b,
    input  logic [4:0]             gate_g
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [2:0]           sel_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [4:0]           rsp_vec_q;
    logic                 rsp_y_q;
    logic                 rsp_err_q;
    logic                 gate_a_q;
    logic                 gate_b_q;
`ifndef GATE_ARB_FIXED_PRI_EN
    logic [IW-1:0]        rr_ptr_q;
`endif

    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [NUM_REQ-1:0]   grant_oh;

    // Winner search. Round-robin walks from rr_ptr with a wrap instead of a
    // modulo so non-power-of-two NUM_REQ stays cheap.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef GATE_ARB_FIXED_PRI_EN
            j = k;
`else
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
`endif
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    // Ready is gated by rst_n so every output reads 0 while reset is held,
    // even though IDLE itself would otherwise advertise a winner.
    always_comb begin
        grant_oh = '0;
        if (state_q == IDLE && win_found && rst_n) grant_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_vec_q   <= '0;
            rsp_y_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
`ifndef GATE_ARB_FIXED_PRI_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        idx_q    <= win_idx;
                        // Operands go straight onto the shared unit so they
                        // are stable from the first DRIVE cycle.
                        gate_a_q <= req_a[win_idx];
                        gate_b_q <= req_b[win_idx];
                        sel_q    <= req_sel[3*win_idx +: 3];
                        cnt_q    <= '0;
`ifndef GATE_ARB_FIXED_PRI_EN
                        rr_ptr_q <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`endif
                        state_q  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == CW'(SETTLE_CYC-1)) begin
                        cnt_q   <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    rsp_vec_q   <= gate_g;
                    rsp_y_q     <= (sel_q <= 3'd4) ? gate_g[sel_q] : 1'b0;
                    rsp_err_q   <= (sel_q > 3'd4);
                    rsp_valid_q <= NUM_REQ'(1) << idx_q;
                    gate_a_q    <= 1'b0;
                    gate_b_q    <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = grant_oh;
    assign rsp_valid = rsp_valid_q;
    assign rsp_vec   = rsp_vec_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign gate_a    = gate_a_q;
    assign gate_b    = gate_b_q;

endmodule
